// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit
// Description : Instruction-fetch front end. Fetches sequentially from
//               instruction memory into a DEPTH-entry {pc, instruction}
//               queue that the decode stage drains via valid/ready.
//               Tolerates memory stalls; a redirect flushes the queue and
//               restarts fetch at the new target.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [XLEN-1:0]            imem_addr,
    output logic                       imem_req,
    input  logic                       imem_ready,
    input  logic [31:0]                imem_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_target,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_pc,
    output logic [31:0]                id_instruction,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [PW-1:0]   c_PTR_ONE    = PW'(1);
    localparam logic [CW-1:0]   c_CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]   c_FULL_COUNT = CW'(DEPTH);
    localparam logic [XLEN-1:0] c_PC_STEP    = XLEN'(PC_STEP);

    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [31:0]     r_instr_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_req;
    logic w_valid;
    logic w_unused_target_lsbs;

    // Word alignment of the redirect target discards its two low bits.
    assign w_unused_target_lsbs = ^redirect_target[1:0];

    // Queue status and handshakes; redirect suppresses both sides.
    assign w_full   = (r_count == c_FULL_COUNT);
    assign w_empty  = (r_count == '0);
    assign w_valid  = ~w_empty & ~redirect_valid;
    assign w_pop    = w_valid & id_ready;
    // A full queue may still fetch when the head leaves in the same cycle.
    assign w_req    = ~redirect_valid & (~w_full | w_pop);
    assign w_push   = w_req & imem_ready;

    assign imem_addr      = r_fetch_pc;
    assign imem_req       = w_req;
    assign id_valid       = w_valid;
    assign id_pc          = w_empty ? '0 : r_pc_mem[r_rd_ptr];
    assign id_instruction = w_empty ? '0 : r_instr_mem[r_rd_ptr];
    assign queue_count    = r_count;

    // Fetch PC, pointers and occupancy; redirect flushes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_target[XLEN-1:2], 2'b00};
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage: capture the returning word with the PC it came from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
            r_instr_mem[r_wr_ptr] <= imem_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue_unit
// Description : Self-checking bench for fetch_queue_unit. A queue-based
//               reference model tracks the expected fetch PC and contents;
//               directed scenarios plus a randomized run compare against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ready;
    logic [31:0]     imem_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instruction;
    logic [CW-1:0]   queue_count;

    int n_checks = 0;
    int n_errors = 0;

    fetch_queue_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ready(imem_ready), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_instruction(id_instruction),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {pc, instruction} and the next fetch PC.
    logic [63:0]     mq [$];
    logic [XLEN-1:0] m_pc;
    logic            e_valid, e_req, e_pop, e_push;
    logic [XLEN-1:0] e_addr, e_pc;
    logic [31:0]     e_instr;
    int              e_count;

    task automatic model_reset();
        mq.delete();
        m_pc = 32'h0;
    endtask

    task automatic drive(input logic rv, input logic [XLEN-1:0] rt,
                         input logic ir, input logic idr);
        redirect_valid  = rv;
        redirect_target = rt;
        imem_ready      = ir;
        id_ready        = idr;
        imem_data       = $urandom;
    endtask

    // Expected outputs for the current inputs, from the queue model.
    task automatic calc_expect();
        e_count = mq.size();
        e_addr  = m_pc;
        e_pc    = (mq.size() == 0) ? 32'h0 : mq[0][63:32];
        e_instr = (mq.size() == 0) ? 32'h0 : mq[0][31:0];
        if (redirect_valid) begin
            e_valid = 1'b0; e_req = 1'b0; e_pop = 1'b0; e_push = 1'b0;
        end else begin
            e_valid = (mq.size() != 0);
            e_pop   = e_valid && id_ready;
            e_req   = (mq.size() < DEPTH) || e_pop;
            e_push  = e_req && imem_ready;
        end
    endtask

    // Clock edge: apply the sampled handshakes to the model.
    task automatic advance();
        @(posedge clk);
        if (redirect_valid) begin
            mq.delete();
            m_pc = {redirect_target[XLEN-1:2], 2'b00};
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (e_push) begin
                mq.push_back({m_pc, imem_data});
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL reset_req got=%b exp=1", imem_req); end
        n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        n_checks++; if (id_pc !== 32'h0 || id_instruction !== 32'h0) begin n_errors++; $display("FAIL reset_id got=%h/%h exp=0/0", id_pc, id_instruction); end
        n_checks++; if (queue_count !== '0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", queue_count); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); calc_expect();
            n_checks++; if (id_valid !== (i > 0)) begin n_errors++; $display("FAIL stream_valid[%0d] got=%b exp=%b", i, id_valid, (i > 0)); end
            if (i > 0) begin
                n_checks++; if (id_pc !== 32'((i-1)*4)) begin n_errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, id_pc, 32'((i-1)*4)); end
                n_checks++; if (id_instruction !== e_instr) begin n_errors++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, id_instruction, e_instr); end
            end
            drive(1'b0, 32'h0, 1'b1, 1'b1);
            advance();
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            int f;
            f = (i < 4) ? i : 4;
            @(negedge clk); calc_expect();
            n_checks++; if (queue_count !== CW'(f)) begin n_errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, queue_count, f); end
            n_checks++; if (imem_req !== (i < 4)) begin n_errors++; $display("FAIL fill_req[%0d] got=%b exp=%b", i, imem_req, (i < 4)); end
            n_checks++; if (imem_addr !== 32'(f*4)) begin n_errors++; $display("FAIL fill_addr[%0d] got=%h exp=%h", i, imem_addr, 32'(f*4)); end
            advance();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); calc_expect();
            n_checks++; if (id_valid !== (j < 4)) begin n_errors++; $display("FAIL drain_valid[%0d] got=%b exp=%b", j, id_valid, (j < 4)); end
            if (j < 4) begin
                n_checks++; if (id_pc !== 32'(j*4)) begin n_errors++; $display("FAIL drain_pc[%0d] got=%h exp=%h", j, id_pc, 32'(j*4)); end
                n_checks++; if (id_instruction !== e_instr) begin n_errors++; $display("FAIL drain_instr[%0d] got=%h exp=%h", j, id_instruction, e_instr); end
            end
            n_checks++; if (queue_count !== CW'(e_count)) begin n_errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", j, queue_count, e_count); end
            advance();
        end
    endtask

    task automatic test_full_flow();
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); calc_expect(); advance();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); calc_expect();
            n_checks++; if (queue_count !== CW'(4)) begin n_errors++; $display("FAIL flow_count[%0d] got=%0d exp=4", i, queue_count); end
            n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL flow_req[%0d] got=%b exp=1", i, imem_req); end
            n_checks++; if (id_pc !== 32'(i*4)) begin n_errors++; $display("FAIL flow_pc[%0d] got=%h exp=%h", i, id_pc, 32'(i*4)); end
            n_checks++; if (id_instruction !== e_instr) begin n_errors++; $display("FAIL flow_instr[%0d] got=%h exp=%h", i, id_instruction, e_instr); end
            drive(1'b0, 32'h0, 1'b1, 1'b1);
            advance();
        end
    endtask

    task automatic test_mem_stall();
        logic [XLEN-1:0] next_pc;
        int hits8;
        next_pc = 32'h0;
        hits8 = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 2)      drive(1'b0, 32'h0, 1'b1, 1'b0);
            else if (i < 5) drive(1'b0, 32'h0, 1'b0, 1'b1);
            else            drive(1'b0, 32'h0, 1'b1, 1'b1);
            @(negedge clk); calc_expect();
            if (i >= 2 && i < 5) begin
                n_checks++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin n_errors++; $display("FAIL stall_hold[%0d] got=%h/%b exp=00000008/1", i, imem_addr, imem_req); end
                n_checks++; if (queue_count !== CW'(4 - i > 0 ? 4 - i : 0)) begin n_errors++; $display("FAIL stall_count[%0d] got=%0d exp=%0d", i, queue_count, (4 - i > 0 ? 4 - i : 0)); end
            end
            if (id_valid && id_ready) begin
                if (id_pc == 32'h8) hits8++;
                n_checks++; if (id_pc !== next_pc) begin n_errors++; $display("FAIL stall_order[%0d] got=%h exp=%h", i, id_pc, next_pc); end
                next_pc = next_pc + 32'd4;
            end
            advance();
        end
        n_checks++; if (hits8 != 1 || next_pc !== 32'h14) begin n_errors++; $display("FAIL stall_once got=%0d/%h exp=1/00000014", hits8, next_pc); end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); calc_expect(); advance();
        end
        drive(1'b1, 32'h103, 1'b1, 1'b1);
        @(negedge clk); calc_expect();
        n_checks++; if (id_valid !== 1'b0 || imem_req !== 1'b0) begin n_errors++; $display("FAIL redir_cycle got=%b/%b exp=0/0", id_valid, imem_req); end
        n_checks++; if (queue_count !== CW'(3)) begin n_errors++; $display("FAIL redir_pre_count got=%0d exp=3", queue_count); end
        advance();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk); calc_expect();
        n_checks++; if (queue_count !== '0 || id_valid !== 1'b0) begin n_errors++; $display("FAIL redir_flush got=%0d/%b exp=0/0", queue_count, id_valid); end
        n_checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin n_errors++; $display("FAIL redir_addr got=%h/%b exp=00000100/1", imem_addr, imem_req); end
        advance();
        @(negedge clk); calc_expect();
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin n_errors++; $display("FAIL redir_first got=%b/%h exp=1/00000100", id_valid, id_pc); end
        advance();
        // Wrap-around of the PC past the top of the address space.
        drive(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        @(negedge clk); calc_expect(); advance();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk); calc_expect(); advance();
        @(negedge clk); calc_expect();
        n_checks++; if (id_pc !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_top got=%h exp=fffffffc", id_pc); end
        advance();
        @(negedge clk); calc_expect();
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_errors++; $display("FAIL wrap_zero got=%b/%h exp=1/00000000", id_valid, id_pc); end
        advance();
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); calc_expect(); advance();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_errors++; $display("FAIL midrst_fetch got=%h/%b exp=0/1", imem_addr, imem_req); end
        n_checks++; if (id_valid !== 1'b0 || queue_count !== '0) begin n_errors++; $display("FAIL midrst_queue got=%b/%0d exp=0/0", id_valid, queue_count); end
        n_checks++; if (id_pc !== 32'h0 || id_instruction !== 32'h0) begin n_errors++; $display("FAIL midrst_id got=%h/%h exp=0/0", id_pc, id_instruction); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge clk); calc_expect(); advance();
        @(negedge clk); calc_expect();
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_errors++; $display("FAIL midrst_restart got=%b/%h exp=1/00000000", id_valid, id_pc); end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 16) == 0, $urandom, ($urandom % 4) != 0, ($urandom % 3) != 0);
            @(negedge clk); calc_expect();
            n_checks++; if (imem_addr !== e_addr || imem_req !== e_req) begin n_errors++; $display("FAIL rand_fetch[%0d] got=%h/%b exp=%h/%b", i, imem_addr, imem_req, e_addr, e_req); end
            n_checks++; if (id_valid !== e_valid || queue_count !== CW'(e_count)) begin n_errors++; $display("FAIL rand_queue[%0d] got=%b/%0d exp=%b/%0d", i, id_valid, queue_count, e_valid, e_count); end
            if (!redirect_valid) begin
                n_checks++; if (id_pc !== e_pc || id_instruction !== e_instr) begin n_errors++; $display("FAIL rand_head[%0d] got=%h/%h exp=%h/%h", i, id_pc, id_instruction, e_pc, e_instr); end
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_full_stall();
        test_full_flow();
        test_mem_stall();
        test_redirect();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
